// File: rtl/dmem_stream_port.sv
// Streaming load/dump engine for the data memory's secondary port: packs an input
// byte stream into little-endian words (load) or unpacks memory words into bytes (dump).
module dmem_stream_port #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      base,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             te,
    output logic [31:0]      ta,
    output logic [31:0]      td,
    input  logic [31:0]      rtd,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        DUMP_RD,
        DUMP_TX,
        DONE
    } state_t;

    state_t           state_reg;
    logic [31:0]      addr_reg;
    logic [31:0]      ta_reg;
    logic [31:0]      word_reg;
    logic [31:0]      rbuf_reg;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] word_cnt_reg;
    logic [1:0]       byte_idx_reg;

    logic [LEN_W-1:0] word_cnt_next;
    logic [31:0]      addr_next;
    logic [7:0]       rbuf_byte [4];

    assign word_cnt_next = word_cnt_reg + LEN_W'(1);
    assign addr_next     = addr_reg + 32'd4;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rbuf_byte[gi] = rbuf_reg[8*gi +: 8];
    end

    // Every output comes from a register, so handshake inputs never reach outputs combinationally.
    assign in_ready  = (state_reg == LOAD);
    assign out_valid = (state_reg == DUMP_TX);
    assign out_data  = rbuf_byte[byte_idx_reg];
    assign te        = (state_reg == WRITE);
    assign ta        = ta_reg;
    assign td        = word_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            ta_reg       <= '0;
            word_reg     <= '0;
            rbuf_reg     <= '0;
            len_reg      <= '0;
            word_cnt_reg <= '0;
            byte_idx_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        addr_reg     <= {base[31:2], 2'b00};
                        len_reg      <= len;
                        word_cnt_reg <= '0;
                        byte_idx_reg <= '0;
                        if (len == '0) begin
                            state_reg <= DONE;
                        end else if (!mode) begin
                            state_reg <= LOAD;
                        end else begin
                            ta_reg    <= {base[31:2], 2'b00};
                            state_reg <= DUMP_RD;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        word_reg[{byte_idx_reg, 3'b000} +: 8] <= in_data;
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        if (byte_idx_reg == 2'd3) begin
                            ta_reg    <= addr_reg;
                            state_reg <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    addr_reg     <= addr_next;
                    word_cnt_reg <= word_cnt_next;
                    byte_idx_reg <= '0;
                    state_reg    <= (word_cnt_next == len_reg) ? DONE : LOAD;
                end
                DUMP_RD: begin
                    rbuf_reg     <= rtd;
                    byte_idx_reg <= '0;
                    state_reg    <= DUMP_TX;
                end
                DUMP_TX: begin
                    if (out_ready) begin
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        if (byte_idx_reg == 2'd3) begin
                            addr_reg     <= addr_next;
                            word_cnt_reg <= word_cnt_next;
                            if (word_cnt_next == len_reg) begin
                                state_reg <= DONE;
                            end else begin
                                // Next read address is presented while DUMP_RD is active.
                                ta_reg    <= addr_next;
                                state_reg <= DUMP_RD;
                            end
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_stream_port.sv
// Randomized scoreboard bench for dmem_stream_port with a word-addressed memory model
// behind the secondary port and an address-keyed reference memory.
module tb_dmem_stream_port;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic             mode = 1'b0;
    logic [31:0]      base = '0;
    logic [LEN_W-1:0] len = '0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_ready = 1'b0;
    logic             te;
    logic [31:0]      ta;
    logic [31:0]      td;
    logic [31:0]      rtd;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    dmem_stream_port #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base(base), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .te(te), .ta(ta), .td(td), .rtd(rtd), .busy(busy), .done(done)
    );

    // data_mem secondary port: 256 words, combinational read, synchronous write.
    logic [31:0] mem [256];
    assign rtd = mem[ta[9:2]];
    always @(posedge clk) if (te) mem[ta[9:2]] <= td;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_wr[$];
    logic [7:0]  exp_byte[$];
    int          exp_done[$];      // 0 = load, 1 = dump, 2 = zero length
    logic [7:0]  stim_bytes[$];
    logic [31:0] ref_mem[int unsigned];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int rdy_mode = 0;              // 0 = held high, 1 = toggle, 2 = random
    int last_te_cyc = -10;
    int last_tx_cyc = -10;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: pops expectations whenever the DUT presents a write, a byte, or done.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
            prev_ready <= 1'b0;
        end else begin
            if (te) begin
                check("in_ready_in_write", 32'(in_ready), 32'd0);
                if (exp_wr.size() == 0) begin
                    check("unexpected_te", 32'(te), 32'd0);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("write_addr", ta, w.a);
                    check("write_data", td, w.d);
                end
                last_te_cyc <= cyc;
            end
            if (prev_valid && !prev_ready) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (exp_byte.size() == 0) begin
                    check("unexpected_byte", 32'(out_valid), 32'd0);
                end else begin
                    check("out_byte", 32'(out_data), 32'(exp_byte.pop_front()));
                end
                last_tx_cyc <= cyc;
            end
            if (done) begin
                check("busy_at_done", 32'(busy), 32'd1);
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    int k;
                    k = exp_done.pop_front();
                    if (k == 0) check("done_after_last_te", 32'(cyc), 32'(last_te_cyc + 1));
                    if (k == 1) check("done_after_last_byte", 32'(cyc), 32'(last_tx_cyc + 1));
                end
            end
            prev_valid <= out_valid;
            prev_ready <= out_ready;
            prev_data  <= out_data;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_te"}, 32'(te), 32'd0);
        check({tag, "_ta"}, ta, 32'd0);
        check({tag, "_td"}, td, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic do_start(input logic m, input logic [31:0] b, input int n);
        @(posedge clk);
        #1;
        start = 1'b1;
        mode  = m;
        base  = b;
        len   = LEN_W'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic feed_byte(input logic [7:0] b, input int gap);
        int k;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        for (k = 0; k < 100; k++) begin
            logic ok;
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (k == 100) check("in_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done_seen", 32'(done), 32'd1);
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic fill_random(input int n);
        stim_bytes.delete();
        for (int i = 0; i < 4 * n; i++) stim_bytes.push_back(8'($urandom));
    endtask

    // Load of stim_bytes; gap_mode 0 = none, 1 = three idle cycles per byte, 2 = random.
    task automatic run_load(input logic [31:0] b, input int n, input int gap_mode);
        logic [31:0] a0;
        a0 = {b[31:2], 2'b00};
        for (int w = 0; w < n; w++) begin
            wr_t e;
            e.a = a0 + 32'(4 * w);
            e.d = {stim_bytes[4*w+3], stim_bytes[4*w+2], stim_bytes[4*w+1], stim_bytes[4*w]};
            exp_wr.push_back(e);
            ref_mem[e.a] = e.d;
        end
        exp_done.push_back(0);
        $display("load  base=%h len=%0d gap_mode=%0d", b, n, gap_mode);
        do_start(1'b0, b, n);
        for (int i = 0; i < 4 * n; i++) begin
            int gap;
            gap = (gap_mode == 1) ? 3 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            feed_byte(stim_bytes[i], (i == 0) ? 0 : gap);
        end
        in_valid = 1'b0;
        wait_done();
    endtask

    task automatic run_dump(input logic [31:0] b, input int n, input int rmode, input logic inject);
        logic [31:0] a0;
        a0 = {b[31:2], 2'b00};
        for (int w = 0; w < n; w++) begin
            logic [31:0] word;
            word = ref_mem[a0 + 32'(4 * w)];
            for (int k = 0; k < 4; k++) exp_byte.push_back(word[8*k +: 8]);
        end
        exp_done.push_back(1);
        rdy_mode = rmode;
        $display("dump  base=%h len=%0d ready_mode=%0d inject_start=%0d", b, n, rmode, inject);
        do_start(1'b1, b, n);
        if (inject) begin
            repeat (3) @(posedge clk);
            #1;
            start = 1'b1;
            mode  = 1'b0;
            base  = 32'h0000_0200;
            len   = LEN_W'(5);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_done();
        rdy_mode = 0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Fixed pattern, unaligned base.
        stim_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_load(32'h0000_0043, 2, 0);
        run_dump(32'h0000_0040, 2, 1, 1'b0);

        // Same bytes with gapped input.
        run_load(32'h0000_0080, 2, 1);
        run_dump(32'h0000_0080, 2, 2, 1'b0);

        // Zero-length request.
        exp_done.push_back(2);
        $display("zero  base=00000000 len=0");
        do_start(1'b0, 32'h0, 0);
        @(negedge clk);
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd1);
        check("zero_te", 32'(te), 32'd0);
        @(negedge clk);
        check("zero_done_clear", 32'(done), 32'd0);
        check("zero_busy_clear", 32'(busy), 32'd0);

        // Reset after two bytes of a load: nothing may be written.
        $display("reset mid-load base=00000100");
        do_start(1'b0, 32'h0000_0100, 2);
        feed_byte(8'hA5, 0);
        feed_byte(8'h5A, 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fill_random(2);
        run_load(32'h0000_0100, 2, 0);

        // Start pulse during a dump must be ignored.
        run_dump(32'h0000_0100, 2, 2, 1'b1);

        // Address wrap.
        fill_random(2);
        run_load(32'hFFFF_FFFC, 2, 2);
        run_dump(32'hFFFF_FFFC, 2, 0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            logic [31:0] b;
            int n;
            b = 32'($urandom_range(32'h140, 32'h37F));
            n = int'($urandom_range(1, 8));
            fill_random(n);
            run_load(b, n, int'($urandom_range(0, 2)));
            run_dump(b, n, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        check("writes_left", 32'(exp_wr.size()), 32'd0);
        check("bytes_left", 32'(exp_byte.size()), 32'd0);
        check("dones_left", 32'(exp_done.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
